// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: scheduler state encoding, datapath widths and the
// standard initial chaining value used by the compression core.
package sm3_pkg;

    localparam int WORD_W        = 32;
    localparam int HASH_W        = 256;
    localparam int WORDS_PER_BLK = 16;

    // Standard SM3 initial value, loaded by the core when CORE_INIT is set
    localparam logic [HASH_W-1:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_COMP  = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/sm3_sched_wdog.sv
// Watchdog for the SM3 block scheduler. Counts cycles spent in the states that
// wait on an external party (REQ, WAIT, COMP) and flags expiry once a single
// visit lasts TIMEOUT_CYC cycles. Only instantiated with SM3_SCHED_TIMEOUT_EN.
module sm3_sched_wdog
    import sm3_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
)(
    input  logic         clk,
    input  logic         rst,
    input  sched_state_t state,
    output logic         expired
);

    localparam int CNT_BITS = $clog2(TIMEOUT_CYC + 1);

    sched_state_t        prev_state;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cycles_in;
    logic                active;
    logic                entering;

    // A state change restarts the count, so this cycle is the first of the visit
    always_comb begin
        active    = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_COMP);
        entering  = (state != prev_state);
        cycles_in = entering ? '0 : cnt;
        expired   = active && (cycles_in == CNT_BITS'(TIMEOUT_CYC - 1));
    end

    // Track the previous state and the running cycle count of the current visit
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state <= ST_IDLE;
            cnt        <= '0;
        end else begin
            prev_state <= state;
            cnt        <= active ? (cycles_in + CNT_BITS'(1)) : '0;
        end
    end

endmodule

// File: rtl/sm3_blk_sched.sv
// SM3 block scheduler: on ENABLE walks BSR 512-bit message blocks starting at
// SAR_ADDR, fetching one word at a time from message memory, streaming words to
// the compression core, starting each compression and latching the final hash.
// Optional watchdog: define SM3_SCHED_TIMEOUT_EN to abort stuck runs with ERR.
module sm3_blk_sched
    import sm3_pkg::*;
#(
    parameter int ADDR_W        = 13,
    parameter int CNT_W         = 13,
    parameter int WORDS_PER_BLK = sm3_pkg::WORDS_PER_BLK,
    parameter int TIMEOUT_CYC   = 1024
)(
    input  logic              AHB_HCLK,
    input  logic              AHB_HRESET,
    input  logic              ENABLE,
    input  logic [ADDR_W-1:0] SAR_ADDR,
    input  logic [CNT_W-1:0]  BSR,
    input  logic              INTR_CLR,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_GNT,
    input  logic              MEM_RVALID,
    input  logic [WORD_W-1:0] MEM_RDATA,
    output logic              MSG_VALID,
    output logic [WORD_W-1:0] MSG_WORD,
    output logic              CORE_START,
    output logic              CORE_INIT,
    input  logic              CORE_DONE,
    input  logic [HASH_W-1:0] CORE_HASH,
    output logic [HASH_W-1:0] TEMP_RES,
    output logic              BUSY,
    output logic              CRYPT_INTR,
    output logic              ERR
);

    localparam int WCNT_W = $clog2(WORDS_PER_BLK + 1);

    sched_state_t      state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  blk_left;
    logic [WCNT_W-1:0] word_cnt;
    logic              first;
    logic              load_hash;

`ifdef SM3_SCHED_TIMEOUT_EN
    logic wdog_expired;
    logic err_q;

    sm3_sched_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (AHB_HCLK),
        .rst     (AHB_HRESET),
        .state   (state),
        .expired (wdog_expired)
    );

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // The read address register doubles as the memory address output
    assign MEM_ADDR = addr;
    assign BUSY     = (state != ST_IDLE);

    // Main sequencer: fetch words, hand them to the core, run compressions, finish
    always_ff @(posedge AHB_HCLK) begin
        if (AHB_HRESET) begin
            state      <= ST_IDLE;
            addr       <= '0;
            blk_left   <= '0;
            word_cnt   <= '0;
            first      <= 1'b0;
            load_hash  <= 1'b0;
            MEM_REQ    <= 1'b0;
            MSG_VALID  <= 1'b0;
            MSG_WORD   <= '0;
            CORE_START <= 1'b0;
            CORE_INIT  <= 1'b0;
            TEMP_RES   <= '0;
            CRYPT_INTR <= 1'b0;
`ifdef SM3_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            MSG_VALID <= 1'b0;

            // Clear comes first so a completion in the same cycle overrides it
            if (INTR_CLR) begin
                CRYPT_INTR <= 1'b0;
`ifdef SM3_SCHED_TIMEOUT_EN
                err_q      <= 1'b0;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (ENABLE) begin
                        if (BSR != '0) begin
                            addr      <= SAR_ADDR;
                            blk_left  <= BSR;
                            first     <= 1'b1;
                            word_cnt  <= '0;
                            load_hash <= 1'b0;
                            MEM_REQ   <= 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            load_hash <= 1'b0;
                            state     <= ST_DONE;
                        end
                    end
                end

                ST_REQ: begin
                    if (MEM_GNT) begin
                        MEM_REQ <= 1'b0;
                        addr    <= addr + ADDR_W'(1);
                        state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (MEM_RVALID) begin
                        MSG_VALID <= 1'b1;
                        MSG_WORD  <= MEM_RDATA;
                        word_cnt  <= word_cnt + WCNT_W'(1);
                        if (word_cnt == WCNT_W'(WORDS_PER_BLK - 1)) begin
                            CORE_START <= 1'b1;
                            CORE_INIT  <= first;
                            state      <= ST_START;
                        end else begin
                            MEM_REQ <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end

                ST_START: begin
                    CORE_START <= 1'b0;
                    CORE_INIT  <= 1'b0;
                    first      <= 1'b0;
                    word_cnt   <= '0;
                    state      <= ST_COMP;
                end

                ST_COMP: begin
                    if (CORE_DONE) begin
                        blk_left <= blk_left - CNT_W'(1);
                        if (blk_left == CNT_W'(1)) begin
                            load_hash <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            MEM_REQ <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end

                ST_DONE: begin
                    if (load_hash) begin
                        TEMP_RES <= CORE_HASH;
                    end
                    load_hash  <= 1'b0;
                    CRYPT_INTR <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

`ifdef SM3_SCHED_TIMEOUT_EN
            // A stuck run is abandoned: drop the request and finish without a hash
            if (wdog_expired) begin
                MEM_REQ   <= 1'b0;
                load_hash <= 1'b0;
                err_q     <= 1'b1;
                state     <= ST_DONE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sm3_blk_sched.sv
// Self-checking bench for sm3_blk_sched: table of complete runs plus directed
// sequences for reset mid-run, completion racing INTR_CLR and the watchdog.
module tb_sm3_blk_sched;
    import sm3_pkg::*;

    localparam int ADDR_W = 13;
    localparam int CNT_W  = 13;
`ifdef SM3_SCHED_TIMEOUT_EN
    localparam int TMO = 32;
`else
    localparam int TMO = 1024;
`endif

    localparam logic [255:0] H_ABC = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] H2    = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [255:0] H3    = 256'hdeadbeef_00112233_44556677_8899aabb_ccddeeff_12345678_9abcdef0_0badf00d;
    localparam logic [255:0] H4    = 256'hffffffff_eeeeeeee_dddddddd_cccccccc_bbbbbbbb_aaaaaaaa_99999999_88888888;
    localparam logic [255:0] H5    = 256'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3_96969696_69696969_0f0f0f0f_f0f0f0f0;
    localparam logic [255:0] H6    = 256'h13579bdf_2468ace0_fdb97531_0eca8642_11223344_55667788_99aabbcc_ddeeff00;
    localparam logic [255:0] H7    = 256'hcafebabe_cafebabe_cafebabe_cafebabe_cafebabe_cafebabe_cafebabe_cafebabe;

    logic              AHB_HCLK = 1'b0;
    logic              AHB_HRESET;
    logic              ENABLE;
    logic [ADDR_W-1:0] SAR_ADDR;
    logic [CNT_W-1:0]  BSR;
    logic              INTR_CLR;
    logic              MEM_REQ;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_GNT = 1'b0;
    logic              MEM_RVALID = 1'b0;
    logic [31:0]       MEM_RDATA = '0;
    logic              MSG_VALID;
    logic [31:0]       MSG_WORD;
    logic              CORE_START;
    logic              CORE_INIT;
    logic              CORE_DONE = 1'b0;
    logic [255:0]      CORE_HASH;
    logic [255:0]      TEMP_RES;
    logic              BUSY;
    logic              CRYPT_INTR;
    logic              ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    bit mem_on     = 1'b1;
    bit stall      = 1'b0;
    int core_lat   = 2;
    bit job_active = 1'b0;

    logic [ADDR_W-1:0] rd_q[$];
    logic [31:0]       msg_q[$];
    logic              init_q[$];
    int                intr_rises = 0;
    int                busy_low   = 0;
    bit                intr_prev  = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] sar;
        logic [CNT_W-1:0]  bsr;
        bit                stall;
        int                lat;
        logic [255:0]      hash;
        int                exp_reads;
        int                exp_starts;
        logic [255:0]      exp_temp;
    } vec_t;

    vec_t vecs[5];

    sm3_blk_sched #(
        .ADDR_W        (ADDR_W),
        .CNT_W         (CNT_W),
        .WORDS_PER_BLK (16),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .AHB_HCLK   (AHB_HCLK),
        .AHB_HRESET (AHB_HRESET),
        .ENABLE     (ENABLE),
        .SAR_ADDR   (SAR_ADDR),
        .BSR        (BSR),
        .INTR_CLR   (INTR_CLR),
        .MEM_REQ    (MEM_REQ),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_GNT    (MEM_GNT),
        .MEM_RVALID (MEM_RVALID),
        .MEM_RDATA  (MEM_RDATA),
        .MSG_VALID  (MSG_VALID),
        .MSG_WORD   (MSG_WORD),
        .CORE_START (CORE_START),
        .CORE_INIT  (CORE_INIT),
        .CORE_DONE  (CORE_DONE),
        .CORE_HASH  (CORE_HASH),
        .TEMP_RES   (TEMP_RES),
        .BUSY       (BUSY),
        .CRYPT_INTR (CRYPT_INTR),
        .ERR        (ERR)
    );

    always #5 AHB_HCLK = ~AHB_HCLK;

    // Message memory contents are a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {3'b101, a, 3'b010, a ^ 13'h1abc};
    endfunction

    // Memory responder: grant a pending request, then return its data, optionally stalling
    always begin
        logic [ADDR_W-1:0] a;
        @(negedge AHB_HCLK);
        MEM_GNT    = 1'b0;
        MEM_RVALID = 1'b0;
        if (mem_on && MEM_REQ === 1'b1) begin
            if (stall) repeat ($urandom_range(0, 2)) @(negedge AHB_HCLK);
            a       = MEM_ADDR;
            MEM_GNT = 1'b1;
            rd_q.push_back(a);
            @(negedge AHB_HCLK);
            MEM_GNT = 1'b0;
            if (stall) repeat ($urandom_range(0, 2)) @(negedge AHB_HCLK);
            MEM_RVALID = 1'b1;
            MEM_RDATA  = mem_word(a);
        end
    end

    // Core model: answer each CORE_START with a one-cycle CORE_DONE after core_lat cycles
    always begin
        @(negedge AHB_HCLK);
        CORE_DONE = 1'b0;
        if (CORE_START === 1'b1) begin
            repeat (core_lat) @(negedge AHB_HCLK);
            CORE_DONE = 1'b1;
        end
    end

    // Monitor: collect words and starts, count interrupt rises and BUSY gaps
    always @(negedge AHB_HCLK) begin
        if (MSG_VALID === 1'b1) msg_q.push_back(MSG_WORD);
        if (CORE_START === 1'b1) init_q.push_back(CORE_INIT);
        if (CRYPT_INTR === 1'b1 && !intr_prev) intr_rises++;
        intr_prev = (CRYPT_INTR === 1'b1);
        if (job_active && BUSY !== 1'b1 && CRYPT_INTR !== 1'b1) busy_low++;
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one run and wait (bounded) for its completion interrupt
    task automatic applyStimulus(input vec_t v, output int cyc);
        @(negedge AHB_HCLK);
        CORE_HASH = v.hash;
        stall     = v.stall;
        core_lat  = v.lat;
        SAR_ADDR  = v.sar;
        BSR       = v.bsr;
        ENABLE    = 1'b1;
        @(negedge AHB_HCLK);
        ENABLE     = 1'b0;
        SAR_ADDR   = ~v.sar;
        BSR        = 13'd5;
        job_active = 1'b1;
        cyc        = 1;
        while (CRYPT_INTR !== 1'b1 && cyc < 3000) begin
            @(negedge AHB_HCLK);
            cyc++;
        end
        job_active = 1'b0;
    endtask

    initial begin
        int cyc;
        int b_rd, b_msg, b_init, b_rises, b_busy;
        int n_words, bad, req_cycles;
        bit hit;

        AHB_HRESET = 1'b1;
        ENABLE     = 1'b0;
        INTR_CLR   = 1'b0;
        SAR_ADDR   = '0;
        BSR        = '0;
        CORE_HASH  = '0;

        vecs[0] = '{13'h0000, 13'd1, 1'b0, 2, H_ABC, 16, 1, H_ABC};
        vecs[1] = '{13'h0100, 13'd3, 1'b1, 3, H2,    48, 3, H2};
        vecs[2] = '{13'h1ff8, 13'd1, 1'b0, 1, H3,    16, 1, H3};
        vecs[3] = '{13'h00a0, 13'd0, 1'b0, 1, H4,     0, 0, H3};
        vecs[4] = '{13'h1ffe, 13'd2, 1'b1, 2, H5,    32, 2, H5};

        repeat (2) @(negedge AHB_HCLK);
        checkOutput("reset_ctrl", 256'({MEM_REQ, MSG_VALID, CORE_START, CORE_INIT, BUSY, CRYPT_INTR, ERR}), '0);
        checkOutput("reset_addr", 256'(MEM_ADDR), '0);
        checkOutput("reset_word", 256'(MSG_WORD), '0);
        checkOutput("reset_temp", TEMP_RES, '0);
        AHB_HRESET = 1'b0;

        for (int k = 0; k < 5; k++) begin
            $display("[TB] run %0d: SAR=%h BSR=%0d", k, vecs[k].sar, vecs[k].bsr);
            b_rd    = rd_q.size();
            b_msg   = msg_q.size();
            b_init  = init_q.size();
            b_rises = intr_rises;
            b_busy  = busy_low;
            applyStimulus(vecs[k], cyc);
            @(negedge AHB_HCLK);
            checkOutput("done_in_time", 256'(cyc < 3000), 256'(1));
            checkOutput("read_count", 256'(rd_q.size() - b_rd), 256'(vecs[k].exp_reads));
            checkOutput("word_count", 256'(msg_q.size() - b_msg), 256'(vecs[k].exp_reads));
            for (int i = 0; i < vecs[k].exp_reads; i++) begin
                logic [ADDR_W-1:0] ea;
                ea = ADDR_W'(int'(vecs[k].sar) + i);
                if (b_rd + i < rd_q.size())
                    checkOutput("read_addr", 256'(rd_q[b_rd + i]), 256'(ea));
                if (b_msg + i < msg_q.size())
                    checkOutput("msg_word", 256'(msg_q[b_msg + i]), 256'(mem_word(ea)));
            end
            checkOutput("start_count", 256'(init_q.size() - b_init), 256'(vecs[k].exp_starts));
            for (int i = 0; i < vecs[k].exp_starts; i++) begin
                if (b_init + i < init_q.size())
                    checkOutput("core_init", 256'(init_q[b_init + i]), 256'(i == 0));
            end
            checkOutput("temp_res", TEMP_RES, vecs[k].exp_temp);
            checkOutput("intr_set", 256'(CRYPT_INTR), 256'(1));
            checkOutput("intr_once", 256'(intr_rises - b_rises), 256'(1));
            checkOutput("busy_held", 256'(busy_low - b_busy), '0);
            checkOutput("idle_after", 256'({BUSY, MEM_REQ}), '0);
            checkOutput("err_clear", 256'(ERR), '0);
            if (vecs[k].bsr == '0)
                checkOutput("zero_blk_latency", 256'(cyc <= 2), 256'(1));
            INTR_CLR = 1'b1;
            @(negedge AHB_HCLK);
            INTR_CLR = 1'b0;
            checkOutput("intr_clr", 256'(CRYPT_INTR), '0);
        end

        $display("[TB] reset during a run, with an ENABLE while busy");
        stall    = 1'b0;
        core_lat = 2;
        b_msg    = msg_q.size();
        b_init   = init_q.size();
        @(negedge AHB_HCLK);
        SAR_ADDR = 13'h040;
        BSR      = 13'd2;
        ENABLE   = 1'b1;
        @(negedge AHB_HCLK);
        ENABLE = 1'b0;
        repeat (3) @(negedge AHB_HCLK);
        SAR_ADDR = 13'h300;
        BSR      = 13'd1;
        ENABLE   = 1'b1;
        @(negedge AHB_HCLK);
        ENABLE = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (msg_q.size() - b_msg >= 7) begin
                hit = 1'b1;
                break;
            end
            @(negedge AHB_HCLK);
        end
        checkOutput("word7_reached", 256'(hit), 256'(1));
        AHB_HRESET = 1'b1;
        @(negedge AHB_HCLK);
        checkOutput("midrun_rst_ctrl", 256'({MEM_REQ, MSG_VALID, CORE_START, CORE_INIT, BUSY, CRYPT_INTR, ERR}), '0);
        checkOutput("midrun_rst_addr", 256'(MEM_ADDR), '0);
        checkOutput("midrun_rst_word", 256'(MSG_WORD), '0);
        checkOutput("midrun_rst_temp", TEMP_RES, '0);
        n_words = msg_q.size() - b_msg;
        bad = 0;
        for (int i = 0; i < n_words; i++) begin
            if (msg_q[b_msg + i] !== mem_word(ADDR_W'(13'h040 + i))) bad++;
        end
        checkOutput("busy_enable_ignored", 256'(bad), '0);
        checkOutput("no_start_before_rst", 256'(init_q.size() - b_init), '0);
        repeat (2) @(negedge AHB_HCLK);
        AHB_HRESET = 1'b0;
        repeat (8) @(negedge AHB_HCLK);
        checkOutput("late_rvalid_ignored", 256'(msg_q.size() - b_msg), 256'(n_words));
        checkOutput("idle_after_rst", 256'({BUSY, MEM_REQ, CRYPT_INTR}), '0);

        $display("[TB] completion coincident with INTR_CLR");
        @(negedge AHB_HCLK);
        CORE_HASH = H6;
        core_lat  = 2;
        SAR_ADDR  = 13'h020;
        BSR       = 13'd1;
        ENABLE    = 1'b1;
        @(negedge AHB_HCLK);
        ENABLE = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge AHB_HCLK);
            if (CORE_DONE === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("core_done_seen", 256'(hit), 256'(1));
        @(negedge AHB_HCLK);
        INTR_CLR = 1'b1;
        @(negedge AHB_HCLK);
        INTR_CLR = 1'b0;
        checkOutput("intr_set_wins", 256'(CRYPT_INTR), 256'(1));
        checkOutput("coincident_hash", TEMP_RES, H6);
        INTR_CLR = 1'b1;
        @(negedge AHB_HCLK);
        INTR_CLR = 1'b0;
        checkOutput("intr_cleared", 256'(CRYPT_INTR), '0);

`ifdef SM3_SCHED_TIMEOUT_EN
        $display("[TB] watchdog with grant held low");
        mem_on = 1'b0;
        @(negedge AHB_HCLK);
        CORE_HASH = H7;
        SAR_ADDR  = 13'h010;
        BSR       = 13'd1;
        ENABLE    = 1'b1;
        @(negedge AHB_HCLK);
        ENABLE = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (ERR === 1'b1) break;
            if (MEM_REQ === 1'b1) req_cycles++;
            @(negedge AHB_HCLK);
        end
        checkOutput("wdog_req_cycles", 256'(req_cycles), 256'(TMO));
        checkOutput("wdog_err", 256'(ERR), 256'(1));
        @(negedge AHB_HCLK);
        checkOutput("wdog_intr", 256'(CRYPT_INTR), 256'(1));
        checkOutput("wdog_temp_kept", TEMP_RES, H6);
        checkOutput("wdog_idle", 256'({BUSY, MEM_REQ}), '0);
        INTR_CLR = 1'b1;
        @(negedge AHB_HCLK);
        INTR_CLR = 1'b0;
        checkOutput("wdog_clr", 256'({ERR, CRYPT_INTR}), '0);
        mem_on = 1'b1;
`else
        req_cycles = 0;
        checkOutput("err_tied_low", 256'(ERR), 256'(req_cycles));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
